// File: rtl/serial_rtype_sequencer_pkg.sv
// Shared constants, state encoding and decode helpers for the serial R-type sequencer.
package serial_rtype_sequencer_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned CTRL_W  = 4;

    localparam logic [6:0]        OPC_RTYPE = 7'b0110011;
    localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_COMMIT = 3'd4
    } state_e;

    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] alu_ctrl;
    } dec_t;

    // Pull register indices and ALU control out of an R-type word.
    function automatic dec_t decode_fields(input logic [INSTR_W-1:0] instr);
        dec_t d;
        d.rs1      = instr[19:15];
        d.rs2      = instr[24:20];
        d.rd       = instr[11:7];
        d.alu_ctrl = {instr[30], instr[14:12]};
        return d;
    endfunction

endpackage

// File: rtl/serial_rtype_sequencer_shift_buffer.sv
// Serial-in, parallel-out instruction buffer; first bit shifted in lands in bit 0.
module serial_shift_buffer
    import serial_rtype_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               din,
    output logic [INSTR_W-1:0] dout
);

    logic [INSTR_W-1:0] sreg_q;
    logic [INSTR_W-1:0] sreg_d;

    // Clear has priority; otherwise right-shift the new bit in at the MSB.
    always_comb begin
        sreg_d = sreg_q;
        if (clear) begin
            sreg_d = '0;
        end else if (shift_en) begin
            sreg_d = {din, sreg_q[INSTR_W-1:1]};
        end
    end

    // Buffer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign dout = sreg_q;

endmodule

// File: rtl/serial_rtype_sequencer.sv
// Bit-serial sequencer: fetches one instruction serially, decodes it and steps a serial ALU.
module serial_rtype_sequencer
    import serial_rtype_sequencer_pkg::*;
#(
    parameter int unsigned XLEN      = serial_rtype_sequencer_pkg::XLEN,
    parameter logic [6:0]  OPC_RTYPE = serial_rtype_sequencer_pkg::OPC_RTYPE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ins,
    input  logic              ins_valid,
    output logic              ins_ready,
    output logic [REG_W-1:0]  rs1_addr,
    output logic [REG_W-1:0]  rs2_addr,
    output logic [REG_W-1:0]  rd_addr,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [CNT_W-1:0]  bit_idx,
    output logic              alu_bit_en,
    output logic              carry_init,
    output logic              rd_wr_en,
    output logic              pc_inc,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]   bit_idx_q, bit_idx_d;
    dec_t               dec_q, dec_d;
    logic               illegal_q, illegal_d;
    logic               ins_ready_q, ins_ready_d;
    logic               alu_bit_en_q, alu_bit_en_d;
    logic               carry_init_q, carry_init_d;
    logic               rd_wr_en_q, rd_wr_en_d;
    logic               pc_inc_q, pc_inc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               buf_clear;
    logic               buf_shift;
    logic [INSTR_W-1:0] instr_w;

    serial_shift_buffer u_buf (
        .clk      (clk),
        .rst_n    (reset),
        .clear    (buf_clear),
        .shift_en (buf_shift),
        .din      (ins),
        .dout     (instr_w)
    );

    // Next-state, counters, decode latch and registered-output decode.
    always_comb begin
        state_d      = state_q;
        fetch_cnt_d  = fetch_cnt_q;
        bit_idx_d    = bit_idx_q;
        dec_d        = dec_q;
        illegal_d    = illegal_q;
        buf_clear    = 1'b0;
        buf_shift    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    fetch_cnt_d = '0;
                    buf_clear   = 1'b1;
                    illegal_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (ins_valid && ins_ready_q) begin
                    buf_shift = 1'b1;
                    if (fetch_cnt_q == CNT_W'(INSTR_W - 1)) begin
                        fetch_cnt_d = '0;
                        state_d     = S_DECODE;
                    end else begin
                        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DECODE: begin
                dec_d     = decode_fields(instr_w);
                bit_idx_d = '0;
                if (instr_w[6:0] == OPC_RTYPE) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_COMMIT;
                end
            end
            S_EXEC: begin
                if (bit_idx_q == CNT_W'(XLEN - 1)) begin
                    bit_idx_d = '0;
                    state_d   = S_COMMIT;
                end else begin
                    bit_idx_d = bit_idx_q + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        ins_ready_d  = (state_d == S_FETCH);
        alu_bit_en_d = (state_d == S_EXEC);
        carry_init_d = alu_bit_en_d && (bit_idx_d == '0) && (dec_d.alu_ctrl == ALU_SUB);
        rd_wr_en_d   = alu_bit_en_d && (dec_d.rd != '0);
        pc_inc_d     = (state_d == S_COMMIT);
        done_d       = (state_d == S_COMMIT);
        busy_d       = (state_d != S_IDLE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            fetch_cnt_q  <= '0;
            bit_idx_q    <= '0;
            dec_q        <= '0;
            illegal_q    <= 1'b0;
            ins_ready_q  <= 1'b0;
            alu_bit_en_q <= 1'b0;
            carry_init_q <= 1'b0;
            rd_wr_en_q   <= 1'b0;
            pc_inc_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bit_idx_q    <= bit_idx_d;
            dec_q        <= dec_d;
            illegal_q    <= illegal_d;
            ins_ready_q  <= ins_ready_d;
            alu_bit_en_q <= alu_bit_en_d;
            carry_init_q <= carry_init_d;
            rd_wr_en_q   <= rd_wr_en_d;
            pc_inc_q     <= pc_inc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ins_ready  = ins_ready_q;
    assign rs1_addr   = dec_q.rs1;
    assign rs2_addr   = dec_q.rs2;
    assign rd_addr    = dec_q.rd;
    assign alu_ctrl   = dec_q.alu_ctrl;
    assign bit_idx    = bit_idx_q;
    assign alu_bit_en = alu_bit_en_q;
    assign carry_init = carry_init_q;
    assign rd_wr_en   = rd_wr_en_q;
    assign pc_inc     = pc_inc_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign illegal    = illegal_q;

endmodule
